// File: rtl/calculator_pkg.sv
// Shared calculator types and constants.
// Adder-side state kept apart from the controller's own FSM.
package calculator_pkg;

  localparam int ADD_DATA_W  = 32;
  localparam int ADD_CHUNK_W = 8;
  localparam int N_CHUNKS    = ADD_DATA_W / ADD_CHUNK_W;
  localparam int MEM_WORD_W  = 2 * ADD_DATA_W;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_CALC  = 2'd1,
    A_STORE = 2'd2
  } adder_state_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit full adder slice.
// Reused each CALC cycle on a different chunk.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  assign {c_o, s_o} = {1'b0, a_i}
                    + {1'b0, b_i}
                    + {{W{1'b0}}, c_i};

endmodule

// File: rtl/adder_result_buffer.sv
// Chunked ripple adder feeding a two-half result buffer.
// One chunk per CALC cycle, LSB first; STORE writes a half.
module adder_result_buffer
  import calculator_pkg::*;
#(
  parameter int DATA_W        = ADD_DATA_W,
  parameter int CHUNK_W       = ADD_CHUNK_W,
  parameter int MEM_WORD_SIZE = MEM_WORD_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [DATA_W-1:0]        op_a_i,
  input  logic [DATA_W-1:0]        op_b_i,
  input  logic                     buffer_control_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DATA_W-1:0]        sum_o,
  output logic                     carry_o,
  output logic [MEM_WORD_SIZE-1:0] buff_result_o,
  output logic                     buff_full_o
);

  localparam int N  = DATA_W / CHUNK_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  adder_state_t state_q;

  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic              half_q;
  logic [KW-1:0]     k_q;
  logic              carry_q;

  logic [CHUNK_W-1:0] a_ch [N];
  logic [CHUNK_W-1:0] b_ch [N];
  logic [CHUNK_W-1:0] part_q [N];
  logic [DATA_W-1:0]  part_sum;

  logic [CHUNK_W-1:0] s_ch;
  logic               c_out;

  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic              vlo_q, vlo_d;
  logic              vhi_q, vhi_d;

  logic is_idle, is_calc, is_store;

  assign is_idle  = (state_q == A_IDLE);
  assign is_calc  = (state_q == A_CALC);
  assign is_store = (state_q == A_STORE);

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign a_ch[i] = op_a_q[i*CHUNK_W +: CHUNK_W];
    assign b_ch[i] = op_b_q[i*CHUNK_W +: CHUNK_W];
    assign part_sum[i*CHUNK_W +: CHUNK_W] = part_q[i];
  end

  chunk_adder #(
    .W (CHUNK_W)
  ) u_chunk (
    .a_i (a_ch[k_q]),
    .b_i (b_ch[k_q]),
    .c_i (carry_q),
    .s_o (s_ch),
    .c_o (c_out)
  );

  // Clear wins first, then a same-cycle store lands on top.
  always_comb begin
    lo_d  = clear_i ? '0 : lo_q;
    hi_d  = clear_i ? '0 : hi_q;
    vlo_d = clear_i ? 1'b0 : vlo_q;
    vhi_d = clear_i ? 1'b0 : vhi_q;
    if (is_store) begin
      if (half_q) begin
        hi_d  = part_sum;
        vhi_d = 1'b1;
      end else begin
        lo_d  = part_sum;
        vlo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= A_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      half_q  <= 1'b0;
      k_q     <= '0;
      carry_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        part_q[i] <= '0;
      end
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (start_i) begin
            op_a_q  <= op_a_i;
            op_b_q  <= op_b_i;
            half_q  <= buffer_control_i;
            k_q     <= '0;
            carry_q <= 1'b0;
            state_q <= A_CALC;
          end
        end
        is_calc: begin
          part_q[k_q] <= s_ch;
          carry_q     <= c_out;
          k_q         <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            state_q <= A_STORE;
          end
        end
        is_store: begin
          state_q <= A_IDLE;
        end
        default: begin
          state_q <= A_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q        <= '0;
      hi_q        <= '0;
      vlo_q       <= 1'b0;
      vhi_q       <= 1'b0;
      buff_full_o <= 1'b0;
      done_o      <= 1'b0;
      sum_o       <= '0;
      carry_o     <= 1'b0;
    end else begin
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      vlo_q       <= vlo_d;
      vhi_q       <= vhi_d;
      buff_full_o <= vlo_d & vhi_d;
      done_o      <= is_store;
      if (is_store) begin
        sum_o   <= part_sum;
        carry_o <= carry_q;
      end
    end
  end

  assign busy_o        = is_calc | is_store;
  assign buff_result_o = {hi_q, lo_q};

endmodule

// File: tb/tb_adder_result_buffer.sv
// Vector table plus scoreboard bench for adder_result_buffer.
// Hand sequences cover clear-in-IDLE and reset mid-CALC.
module tb_adder_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        buffer_control_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] sum_o;
  logic        carry_o;
  logic [63:0] buff_result_o;
  logic        buff_full_o;

  adder_result_buffer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .buffer_control_i (buffer_control_i),
    .clear_i          (clear_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .sum_o            (sum_o),
    .carry_o          (carry_o),
    .buff_result_o    (buff_result_o),
    .buff_full_o      (buff_full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        half;
    logic        clr;
    logic        restart;
    logic [31:0] sum;
    logic        carry;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic [63:0] buff;
    logic        full;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  logic [31:0] m_lo = '0;
  logic [31:0] m_hi = '0;
  logic        m_vlo = 1'b0;
  logic        m_vhi = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    exp_t got;
    int   n;
    if (v.clr) begin
      m_lo = '0; m_hi = '0; m_vlo = 1'b0; m_vhi = 1'b0;
    end
    if (v.half) begin
      m_hi = v.sum; m_vhi = 1'b1;
    end else begin
      m_lo = v.sum; m_vlo = 1'b1;
    end
    e.sum = v.sum;
    e.carry = v.carry;
    e.buff = {m_hi, m_lo};
    e.full = m_vlo & m_vhi;
    sb.push_back(e);

    start_i = 1'b1;
    op_a_i = v.a;
    op_b_i = v.b;
    buffer_control_i = v.half;
    @(negedge clk_i);
    n = 0;
    start_i = 1'b0;
    chk("busy_after_accept", 64'(busy_o), 64'd1);
    chk("done_low_after_accept", 64'(done_o), 64'd0);
    while (n < 12) begin
      @(negedge clk_i);
      n++;
      start_i = 1'b0;
      if (n == 1) begin
        op_a_i = $urandom;
        op_b_i = $urandom;
        buffer_control_i = ~v.half;
      end
      if (n == 2 && v.restart) begin
        start_i = 1'b1;
        op_a_i = 32'h0000_0001;
        op_b_i = 32'h0000_0001;
      end
      clear_i = (n == 4) && v.clr;
      if (done_o) break;
    end
    clear_i = 1'b0;
    chk("done_latency", 64'(n), 64'd5);
    if (done_o && sb.size() > 0) begin
      got = sb.pop_front();
      chk("sum_o", 64'(sum_o), 64'(got.sum));
      chk("carry_o", 64'(carry_o), 64'(got.carry));
      chk("buff_result_o", buff_result_o, got.buff);
      chk("buff_full_o", 64'(buff_full_o), 64'(got.full));
    end else begin
      chk("done_timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_sum"}, 64'(sum_o), 64'd0);
    chk({tag, "_carry"}, 64'(carry_o), 64'd0);
    chk({tag, "_buff"}, buff_result_o, 64'd0);
    chk({tag, "_full"}, 64'(buff_full_o), 64'd0);
  endtask

  initial begin
    int   seen;
    vec_t v;
    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b0};
    vecs[2] = '{32'h1000_0000, 32'h2000_0000, 1'b1, 1'b0, 1'b0, 32'h3000_0000, 1'b0};
    vecs[3] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0};
    vecs[4] = '{32'h0000_0011, 32'h0000_0022, 1'b1, 1'b1, 1'b0, 32'h0000_0033, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'hEFBE_D000, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1};

    repeat (3) @(negedge clk_i);
    chk_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i]);
    end

    @(negedge clk_i);
    chk("single_done_pulse", 64'(done_o), 64'd0);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    m_lo = '0; m_hi = '0; m_vlo = 1'b0; m_vhi = 1'b0;
    chk("idle_clear_buff", buff_result_o, 64'd0);
    chk("idle_clear_full", 64'(buff_full_o), 64'd0);

    v = '{32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0007, 1'b0};
    run_op(v);

    start_i = 1'b1;
    op_a_i = 32'hAAAA_AAAA;
    op_b_i = 32'h5555_5555;
    buffer_control_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk_zero("midcalc_reset");
    m_lo = '0; m_hi = '0; m_vlo = 1'b0; m_vhi = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (done_o) seen++;
    end
    chk("no_done_after_reset", 64'(seen), 64'd0);

    v = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h2345_6789, 1'b0};
    run_op(v);
    v = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 1'b0};
    run_op(v);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_result_buffer.md
Name: adder_result_buffer

Overview:
- Sits between the calculator controller and memory write-back: it takes the controller's operands (op_a/op_b) and half-select (buffer_control) and returns the 64-bit packed result word (buff_result).
- The sum is computed by a multi-cycle chunked ripple adder, CHUNK_W bits per cycle, LSB first, to meet timing at DATA_W=32.
- The finished sum is stored into the upper or lower half of a 64-bit result buffer.
- A start/done handshake and per-half valid flags let the controller know when the word is ready to write.

Parameters:
- DATA_W, 32, operand and sum width.
- CHUNK_W, 8, bits added per CALC cycle; DATA_W % CHUNK_W must be 0.
- MEM_WORD_SIZE, 64, result buffer width; must equal 2*DATA_W.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  request a sum; accepted only in IDLE.
- op_a_i  in  DATA_W  operand A, sampled on the accepting edge.
- op_b_i  in  DATA_W  operand B, sampled on the accepting edge.
- buffer_control_i  in  1  half select (1 = upper, 0 = lower), sampled with the operands.
- clear_i  in  1  clear buffer contents and valid flags.
- busy_o  out  1  high while in CALC or STORE.
- done_o  out  1  one-cycle pulse in the cycle after STORE.
- sum_o  out  DATA_W  last completed sum; held until the next STORE.
- carry_o  out  1  carry out of the MSB of the last sum.
- buff_result_o  out  MEM_WORD_SIZE  {upper half, lower half}.
- buff_full_o  out  1  both halves valid since the last clear.

Behaviour:
- Reset (async assert, sync deassert is external):
  - state = IDLE.
  - All outputs 0: busy_o, done_o, sum_o, carry_o, buff_result_o, buff_full_o.
  - Internal registers 0: valid_lo, valid_hi, chunk counter, carry register.
- FSM states:
  - IDLE: start_i=1 latches op_a, op_b and half select, clears the carry register and chunk index; next state CALC.
  - CALC: each cycle adds the chunk at index k with the carry-in, writes that chunk of the partial sum, updates carry, k++. After N = DATA_W/CHUNK_W cycles (4 at defaults), next state STORE.
  - STORE, when the half select was 0: buffer[31:0] = sum and valid_lo=1.
  - STORE, when the half select was 1: buffer[63:32] = sum and valid_hi=1.
  - STORE, always: sum_o and carry_o update; next state IDLE with done_o=1 in that following cycle.
- Latency: start accepted at edge t, done_o high during cycle t+N+1 (cycle t+5 at defaults), buff_result_o updated in the same cycle as done_o.
- Back-to-back: a new start_i may be accepted in the same cycle done_o is high. Throughput is one sum per N+2 cycles.
- Arithmetic: modulo 2^DATA_W; carry_o is the final MSB carry. There is no signed overflow output.
- buff_full_o = valid_lo & valid_hi, registered.
- Rewriting a half that is already valid overwrites it; the valid flag stays set.
- Boundary and ordering rules:
  - start_i while busy_o=1: ignored; operands are not re-sampled.
  - clear_i in IDLE or CALC: buffer = 0, valid flags = 0; an in-flight CALC continues unaffected.
  - clear_i in the same cycle as STORE: clear applies first, then the store. Result: only the stored half is valid and nonzero, the other half is 0, and buff_full_o=0.
  - Operand and half-select changes after acceptance have no effect.
  - rst_ni low mid-CALC: immediate return to reset values; no done_o pulse. The buffer is cleared.

Decomposition:
- calculator_pkg gets:
  - adder_state_t enum {A_IDLE, A_CALC, A_STORE}, kept separate from the controller's state_t.
  - ADD_CHUNK_W = 8.
  - N_CHUNKS = DATA_W/ADD_CHUNK_W.
- One sub-module, chunk_adder: a combinational CHUNK_W-bit full adder with carry-in and carry-out, instantiated once and multiplexed by the chunk index.

Test Plan:
- Wrap/carry: start with 0x0000_0001 + 0xFFFF_FFFF, half=0 -> done_o exactly 5 cycles after the accepting edge; sum_o=0, carry_o=1, buff_result_o=0x0000_0000_0000_0000, buff_full_o=0.
- Pack both halves: 5+7 half=0, then 0x1000_0000 + 0x2000_0000 half=1 -> buff_result_o=0x3000_0000_0000_000C, buff_full_o=1 after the second done_o.
- Start while busy: start_i re-pulsed 2 cycles into CALC with different operands -> single done_o with the first sum; the second request is ignored.
- Clear collision: halves full, then clear_i asserted in the STORE cycle of 0x11+0x22 half=1 -> buff_result_o=0x0000_0033_0000_0000, buff_full_o=0.
- Reset mid-CALC: rst_ni low for 1 cycle during the 2nd CALC cycle -> all outputs 0 immediately, no done_o; a new start afterwards completes normally.
- Chunk carry chain: 0x00FF_FFFF + 0x0000_0001 -> sum_o=0x0100_0000, carry_o=0, proving carry propagates across chunk boundaries.
